xcvr_test_mgr: RTL and testbench

XCVR_TEST_MGR -- requirements
Module: xcvr_test_mgr

---
 rtl/xcvr_test_mgr.sv | 212 +++++++++++++++++++++
 tb/tb_xcvr_test_mgr.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xcvr_test_mgr.sv
// xcvr_test_mgr: per-channel PRBS31 generators and lock/error checkers with selectable statistics.
// Define XCVR_TEST_ERR_INJECT_EN to build single-bit TX error injection driven by inject_err.
module xcvr_test_mgr #(
  parameter int NUM_CH     = 12,
  parameter int DATA_W     = 32,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 8
) (
  input  logic                     clk_100_clk,
  input  logic                     reset_100_reset,
  input  logic                     test_en,
  input  logic [NUM_CH-1:0]        tx_ready,
  output logic [NUM_CH*DATA_W-1:0] tx_data,
  input  logic [NUM_CH-1:0]        rx_valid,
  input  logic [NUM_CH*DATA_W-1:0] rx_data,
  input  logic                     clear_cnt,
  input  logic [3:0]               ch_sel,
  output logic [NUM_CH-1:0]        stat_locked,
  output logic [31:0]              stat_err_cnt,
  output logic [47:0]              stat_word_cnt,
  output logic [15:0]              stat_loss_cnt,
  input  logic [NUM_CH-1:0]        inject_err
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);
  localparam int POP_W  = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HUNT, ST_LOCKED} state_t;

  // State holds the last 31 bits of the stream, bit 0 most recent; word MSB is the earliest new bit.
  function automatic logic [DATA_W-1:0] prbs_word(input logic [30:0] st);
    logic [30:0] s;
    logic        b;
    s         = st;
    prbs_word = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      b            = s[30] ^ s[27];
      prbs_word[i] = b;
      s            = {s[29:0], b};
    end
  endfunction

  logic [31:0] err_arr  [NUM_CH];
  logic [47:0] word_arr [NUM_CH];
  logic [15:0] loss_arr [NUM_CH];

`ifndef XCVR_TEST_ERR_INJECT_EN
  logic unused_inject;
  assign unused_inject = ^inject_err;
`endif

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [30:0]       gen_q, gen_d;
    logic              tx_act_q;
    logic [DATA_W-1:0] tx_q, tx_d, cur_w;
    logic              adv;

    // tx_q always shows prbs_word(gen_q) once active; the state advances when that word is taken.
    assign cur_w = prbs_word(gen_q);
    assign adv   = test_en & tx_act_q & tx_ready[n];

`ifdef XCVR_TEST_ERR_INJECT_EN
    logic inj_pend_q, inj_pend_d;
`endif

    always_comb begin
      gen_d = adv ? cur_w[30:0] : gen_q;
      tx_d  = test_en ? prbs_word(gen_d) : '0;
`ifdef XCVR_TEST_ERR_INJECT_EN
      inj_pend_d = inj_pend_q | inject_err[n];
      if (adv) begin
        tx_d[0]    = tx_d[0] ^ inj_pend_d;
        inj_pend_d = 1'b0;
      end
`endif
    end

    always_ff @(posedge clk_100_clk) begin
      if (reset_100_reset) begin
        gen_q    <= '1;
        tx_q     <= '0;
        tx_act_q <= 1'b0;
`ifdef XCVR_TEST_ERR_INJECT_EN
        inj_pend_q <= 1'b0;
`endif
      end else begin
        gen_q    <= gen_d;
        tx_q     <= tx_d;
        tx_act_q <= test_en;
`ifdef XCVR_TEST_ERR_INJECT_EN
        inj_pend_q <= inj_pend_d;
`endif
      end
    end

    assign tx_data[n*DATA_W +: DATA_W] = tx_q;

    state_t            state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [BAD_W-1:0]  bad_q, bad_d;
    logic [30:0]       seed_q, seed_d;
    logic [31:0]       err_q, err_d;
    logic [47:0]       word_q, word_d;
    logic [15:0]       loss_q, loss_d;
    logic              locked_q;
    logic [DATA_W-1:0] rx_w, exp_w;
    logic [POP_W-1:0]  pop_w;
    logic [32:0]       err_sum;

    assign rx_w    = rx_data[n*DATA_W +: DATA_W];
    assign exp_w   = prbs_word(seed_q);
    assign pop_w   = POP_W'($countones(rx_w ^ exp_w));
    assign err_sum = {1'b0, err_q} + {{(33-POP_W){1'b0}}, pop_w};

    always_comb begin
      state_d = state_q;
      good_d  = good_q;
      bad_d   = bad_q;
      seed_d  = seed_q;
      err_d   = err_q;
      word_d  = word_q;
      loss_d  = loss_q;
      if (!test_en) begin
        state_d = ST_IDLE;
        good_d  = '0;
        bad_d   = '0;
      end else begin
        case (state_q)
          ST_IDLE: state_d = ST_HUNT;
          ST_HUNT: if (rx_valid[n]) begin
            seed_d = rx_w[30:0];
            bad_d  = '0;
            if (rx_w != exp_w) begin
              good_d = '0;
            end else if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
              good_d  = '0;
              state_d = ST_LOCKED;
            end else begin
              good_d = good_q + GOOD_W'(1);
            end
          end
          ST_LOCKED: if (rx_valid[n]) begin
            // Lock trusts the local sequence: the expectation self-advances, never reseeds.
            seed_d = exp_w[30:0];
            err_d  = err_sum[32] ? '1 : err_sum[31:0];
            word_d = (&word_q) ? word_q : word_q + 48'd1;
            if (pop_w == '0) begin
              bad_d = '0;
            end else if (bad_q == BAD_W'(UNLOCK_CNT - 1)) begin
              bad_d   = '0;
              good_d  = '0;
              state_d = ST_HUNT;
              loss_d  = (&loss_q) ? loss_q : loss_q + 16'd1;
            end else begin
              bad_d = bad_q + BAD_W'(1);
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
      if (clear_cnt) begin
        err_d  = '0;
        word_d = '0;
        loss_d = '0;
      end
    end

    always_ff @(posedge clk_100_clk) begin
      if (reset_100_reset) begin
        state_q  <= ST_IDLE;
        good_q   <= '0;
        bad_q    <= '0;
        seed_q   <= '0;
        err_q    <= '0;
        word_q   <= '0;
        loss_q   <= '0;
        locked_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        good_q   <= good_d;
        bad_q    <= bad_d;
        seed_q   <= seed_d;
        err_q    <= err_d;
        word_q   <= word_d;
        loss_q   <= loss_d;
        locked_q <= (state_d == ST_LOCKED);
      end
    end

    assign stat_locked[n] = locked_q;
    assign err_arr[n]     = err_q;
    assign word_arr[n]    = word_q;
    assign loss_arr[n]    = loss_q;
  end

  logic sel_ok;
  assign sel_ok = ({1'b0, ch_sel} < 5'(NUM_CH));

  always_ff @(posedge clk_100_clk) begin
    if (reset_100_reset || !sel_ok) begin
      stat_err_cnt  <= '0;
      stat_word_cnt <= '0;
      stat_loss_cnt <= '0;
    end else begin
      stat_err_cnt  <= err_arr[ch_sel];
      stat_word_cnt <= word_arr[ch_sel];
      stat_loss_cnt <= loss_arr[ch_sel];
    end
  end

endmodule

// File: tb/tb_xcvr_test_mgr.sv
// Self-checking bench for xcvr_test_mgr: looped-back PRBS traffic with random errors and valid gaps.
// Build with XCVR_TEST_ERR_INJECT_EN defined to also exercise the error injection step.
module tb_xcvr_test_mgr;
  localparam int NUM_CH     = 12;
  localparam int DATA_W     = 32;
  localparam int LOCK_CNT   = 16;
  localparam int UNLOCK_CNT = 8;
  localparam int BUS_W      = NUM_CH * DATA_W;

  logic              clk_100_clk = 1'b0;
  logic              reset_100_reset = 1'b1;
  logic              test_en = 1'b0;
  logic              clear_cnt = 1'b0;
  logic [NUM_CH-1:0] tx_ready = '0;
  logic [NUM_CH-1:0] rx_valid = '0;
  logic [NUM_CH-1:0] inject_err = '0;
  logic [NUM_CH-1:0] stat_locked;
  logic [BUS_W-1:0]  tx_data, rx_data;
  logic [BUS_W-1:0]  err_mask = '0;
  logic [3:0]        ch_sel = '0;
  logic [31:0]       stat_err_cnt;
  logic [47:0]       stat_word_cnt;
  logic [15:0]       stat_loss_cnt;

  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];
  bit hist[$];
  bit tx_live = 1'b0;

  // clock/reset block
  always #5 clk_100_clk = ~clk_100_clk;

  // loopback channel with bench-controlled bit flips
  assign rx_data = tx_data ^ err_mask;

  xcvr_test_mgr #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)
  ) dut (
    .clk_100_clk(clk_100_clk),
    .reset_100_reset(reset_100_reset),
    .test_en(test_en),
    .tx_ready(tx_ready),
    .tx_data(tx_data),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .clear_cnt(clear_cnt),
    .ch_sel(ch_sel),
    .stat_locked(stat_locked),
    .stat_err_cnt(stat_err_cnt),
    .stat_word_cnt(stat_word_cnt),
    .stat_loss_cnt(stat_loss_cnt),
    .inject_err(inject_err)
  );

  // reference PRBS31: bit k = bit(k-31) xor bit(k-28), history seeded with 31 ones
  function automatic logic [DATA_W-1:0] model_word();
    logic [DATA_W-1:0] w = '0;
    bit nb;
    for (int i = 0; i < DATA_W; i++) begin
      nb = hist[0] ^ hist[3];
      hist.push_back(nb);
      void'(hist.pop_front());
      w = {w[DATA_W-2:0], nb};
    end
    return w;
  endfunction

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < 31; i++) hist.push_back(1'b1);
    exp_q.delete();
    exp_q.push_back(model_word());
    tx_live = 1'b0;
  endfunction

  function automatic logic [BUS_W-1:0] mask_bits(input int ch, input int nb);
    logic [DATA_W-1:0] m = '0;
    logic [BUS_W-1:0]  full = '0;
    while ($countones(m) < nb) m[$urandom_range(0, DATA_W-1)] = 1'b1;
    full[ch*DATA_W +: DATA_W] = m;
    return full;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one clock with tx_ready = rx_valid = vld; scoreboard tracks channel 0 tx words
  task automatic step(input logic [NUM_CH-1:0] vld, input logic [BUS_W-1:0] mask, input logic clr);
    tx_ready  = vld;
    rx_valid  = vld;
    err_mask  = mask;
    clear_cnt = clr;
    @(posedge clk_100_clk);
    if (tx_live && test_en && vld[0]) begin
      void'(exp_q.pop_front());
      exp_q.push_back(model_word());
    end
    tx_live = test_en;
    @(negedge clk_100_clk);
    if (tx_live) chk("tx_word", 64'(tx_data[DATA_W-1:0]), 64'(exp_q[0]));
  endtask

  initial begin
    int exp_err;
    int exp_words;
    int nb;
    int sel;
    logic [NUM_CH-1:0] v;
    logic [BUS_W-1:0] m;

    model_reset();
    repeat (3) @(posedge clk_100_clk);
    @(negedge clk_100_clk);
    chk("rst_tx", 64'(|tx_data), 64'd0);
    chk("rst_locked", 64'(stat_locked), 64'd0);
    chk("rst_err", 64'(stat_err_cnt), 64'd0);
    chk("rst_word", 64'(stat_word_cnt), 64'd0);
    chk("rst_loss", 64'(stat_loss_cnt), 64'd0);
    reset_100_reset = 1'b0;

    // initial lock on all channels
    test_en = 1'b1;
    for (int i = 1; i <= LOCK_CNT + 2; i++) begin
      step('1, '0, 1'b0);
      if (i == LOCK_CNT) chk("pre_lock", 64'(stat_locked), 64'd0);
    end
    chk("lock_all", 64'(stat_locked), 64'(12'hfff));
    chk("lock_err0", 64'(stat_err_cnt), 64'd0);

    // channel 3: five flipped bits, then random isolated error words
    ch_sel = 4'd3;
    step('1, '0, 1'b1);
    step('1, mask_bits(3, 5), 1'b0);
    exp_err = 5;
    step('1, '0, 1'b0);
    step('1, '0, 1'b0);
    chk("ch3_err5", 64'(stat_err_cnt), 64'd5);
    chk("ch3_locked", 64'(stat_locked[3]), 64'd1);
    chk("ch3_loss0", 64'(stat_loss_cnt), 64'd0);
    repeat (6) begin
      nb = $urandom_range(1, 8);
      step('1, mask_bits(3, nb), 1'b0);
      exp_err += nb;
      repeat ($urandom_range(1, 3)) step('1, '0, 1'b0);
    end
    step('1, '0, 1'b0);
    step('1, '0, 1'b0);
    chk("ch3_err_rand", 64'(stat_err_cnt), 64'(exp_err));
    chk("ch3_still_locked", 64'(stat_locked[3]), 64'd1);

    // channel 0: consecutive errored words drop lock, clean words relock
    ch_sel = 4'd0;
    for (int i = 1; i <= UNLOCK_CNT; i++) begin
      step('1, mask_bits(0, $urandom_range(1, 4)), 1'b0);
      if (i == UNLOCK_CNT - 1) chk("ch0_before_drop", 64'(stat_locked[0]), 64'd1);
    end
    chk("ch0_unlocked", 64'(stat_locked[0]), 64'd0);
    chk("others_locked", 64'(stat_locked[NUM_CH-1:1]), 64'(11'h7ff));
    for (int i = 1; i <= LOCK_CNT; i++) begin
      step('1, '0, 1'b0);
      if (i == LOCK_CNT - 1) chk("ch0_hunting", 64'(stat_locked[0]), 64'd0);
    end
    chk("ch0_relocked", 64'(stat_locked[0]), 64'd1);
    chk("ch0_loss1", 64'(stat_loss_cnt), 64'd1);

    // alternating valid for 100 valid words on a random channel
    sel = $urandom_range(0, NUM_CH - 1);
    ch_sel = 4'(sel);
    step('1, '0, 1'b1);
    for (int i = 0; i < 200; i++) step((i % 2 == 0) ? '1 : '0, '0, 1'b0);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    chk("toggle_words", 64'(stat_word_cnt), 64'd100);
    chk("toggle_err", 64'(stat_err_cnt), 64'd0);
    chk("toggle_locked", 64'(stat_locked), 64'(12'hfff));

    // random per-channel valid; corrupt only words that are not valid
    step('1, '0, 1'b1);
    exp_words = 0;
    repeat (150) begin
      v = NUM_CH'($urandom);
      m = (!v[sel] && $urandom_range(0, 1) == 1) ? mask_bits(sel, $urandom_range(1, 6)) : '0;
      step(v, m, 1'b0);
      if (v[sel]) exp_words++;
    end
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    chk("rand_words", 64'(stat_word_cnt), 64'(exp_words));
    chk("rand_err", 64'(stat_err_cnt), 64'd0);
    chk("rand_locked", 64'(stat_locked), 64'(12'hfff));

    // clear beats a simultaneous error; out-of-range ch_sel reads zero
    ch_sel = 4'd3;
    step('1, '0, 1'b1);
    step('1, mask_bits(3, 3), 1'b0);
    step('1, '0, 1'b0);
    step('1, '0, 1'b0);
    chk("ch3_err3", 64'(stat_err_cnt), 64'd3);
    step('1, mask_bits(3, 2), 1'b1);
    step('1, '0, 1'b0);
    chk("clear_wins", 64'(stat_err_cnt), 64'd0);
    ch_sel = 4'd13;
    step('1, '0, 1'b0);
    chk("sel13_err", 64'(stat_err_cnt), 64'd0);
    chk("sel13_word", 64'(stat_word_cnt), 64'd0);
    chk("sel13_loss", 64'(stat_loss_cnt), 64'd0);
    ch_sel = 4'd0;
    step('1, '0, 1'b0);
    chk("ch0_words2", 64'(stat_word_cnt), 64'd2);

    // test_en low returns checkers to idle and silences tx
    test_en = 1'b0;
    step('1, '0, 1'b0);
    chk("dis_locked", 64'(stat_locked), 64'd0);
    chk("dis_tx", 64'(|tx_data), 64'd0);
    test_en = 1'b1;
    repeat (LOCK_CNT + 2) step('1, '0, 1'b0);
    chk("relock_all", 64'(stat_locked), 64'(12'hfff));

`ifdef XCVR_TEST_ERR_INJECT_EN
    ch_sel = 4'd5;
    step('1, '0, 1'b1);
    inject_err = 12'h020;
    step('1, '0, 1'b0);
    inject_err = '0;
    repeat (3) step('1, '0, 1'b0);
    chk("inj_ch5", 64'(stat_err_cnt), 64'd1);
    ch_sel = 4'd4;
    step('1, '0, 1'b0);
    chk("inj_ch4", 64'(stat_err_cnt), 64'd0);
`endif

    // reset in the middle of traffic, then generator restarts from the seed
    ch_sel = 4'd0;
    reset_100_reset = 1'b1;
    clear_cnt = 1'b0;
    @(posedge clk_100_clk);
    @(negedge clk_100_clk);
    chk("mid_rst_tx", 64'(|tx_data), 64'd0);
    chk("mid_rst_locked", 64'(stat_locked), 64'd0);
    chk("mid_rst_word", 64'(stat_word_cnt), 64'd0);
    reset_100_reset = 1'b0;
    test_en = 1'b0;
    model_reset();
    test_en = 1'b1;
    repeat (4) step('1, '0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
